softmax_max_sub_q88: RTL
========================

Name: softmax_max_sub_q88

Overview:
- First arithmetic stage of the Q8.8 softmax approximation datapath.
- Sits directly downstream of the vector stimulus/source FSM, which drives en, valid_in and in_x_flat.
- Finds the signed maximum of the N Q8.8 inputs with a pipelined comparator tree, then subtracts that maximum from every element.
- Output elements are all <= 0, ready for the exp-approximation stage; the max is also output.

Parameters:
- N, 8, number of vector elements; power of two, N >= 2.
- LOG2N, $clog2(N), tree depth; derived, never overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  pipeline advance enable; 0 freezes every register in the block.
- valid_in  input  1  in_x_flat holds a vector this cycle; sampled only when en=1.
- in_x_flat  input  N*16  N signed Q8.8 elements; element i at bits [16*i+15:16*i], element 0 in the LSBs.
- valid_out  output  1  sub_x_flat and max_out hold a result.
- max_out  output  16  signed Q8.8 maximum of the vector.
- sub_x_flat  output  N*16  x_i - max, saturated; same packing as in_x_flat.

Behaviour:
- Reset: on a clk edge with rst=1, all pipeline registers clear. valid_out=0, max_out=0, sub_x_flat=0. rst overrides en.
- Pipeline depth L = LOG2N + 1 stages: LOG2N max-tree levels plus 1 subtract stage. For N=8, L=4.
- Each stage has a valid bit, the partial-max registers for its tree level, and a delay-line copy of the full input vector.
- Latency: a vector accepted at edge t (en=1, valid_in=1) appears with valid_out=1 after edge t+L-1, provided en=1 on every intervening edge.
- Stall: an edge with en=0 holds every register, valid bits included. Outputs stay stable and valid_out keeps its value. An edge with en=0 does not accept valid_in.
- Throughput: one vector per enabled cycle. Back-to-back valid_in produces back-to-back valid_out.
- Bubble: valid_in=0 with en=1 shifts a 0 valid bit through the pipe.
- Data registers may load don't-care values when valid=0. Outputs are don't-care when valid_out=0, except after reset, where they are 0.
- Compare: two's-complement signed, per tree node max(a,b) = (a >= b) ? a : b. Ties select either operand; the value is identical.
- Subtract: 17-bit signed difference x_i - max. Since x_i <= max, the result is <= 0.
  - If the result is < -32768, saturate to 16'h8000.
  - There is no positive-overflow path.
- Reset mid-operation: all in-flight vectors are discarded. No valid_out appears for them. valid_out=0 on the edge after rst is asserted.
- en and rst high together: reset wins.
- No handshake back-pressure port. The downstream consumer controls flow only through the shared en.

Decomposition:
- Package softmax_q88_pkg holds:
  - Q88_W = 16.
  - Q88_MIN = 16'h8000.
  - Function q88_sat_sub(a,b): 17-bit subtract with negative saturation.
- Sub-module q88_max_tree:
  - Parameterised by N.
  - Registered signed max reduction with en hold and sync reset.
  - Outputs max and a valid bit after LOG2N enabled edges.
- The top level adds the vector delay line and the subtract stage.

Test Plan:
1. N=8, all elements 16'h0100, one valid cycle, en=1 -> valid_out=1 exactly 4 cycles later, max_out=16'h0100, every sub_x element 16'h0000.
2. Elements {FE00,FF00,FD00,FE80,FF80,FC00,FE00,FF00} (element 0 first) -> max_out=16'hFF80; element 0 result 16'hFE80, element 4 result 16'h0000, element 5 result 16'hFC80.
3. Saturation: element 3 = 16'h7FFF, element 6 = 16'h8000, the rest 0 -> max_out=16'h7FFF; element 6 result 16'h8000 (saturated); element 0 result 16'h8001.
4. Three vectors on consecutive cycles (values as tests 1, 2, 3) -> valid_out high for 3 consecutive cycles with the matching results in order.
5. Stall: launch vector of test 2, drop en for 2 cycles at launch+1 -> valid_out arrives 2 cycles later; results unchanged; outputs frozen while en=0.
6. Reset: launch two vectors, assert rst for 1 cycle at launch+2 -> valid_out stays 0 for both; outputs read 0; a vector launched after rst deasserts completes with normal latency.

Source files
------------

// File: rtl/softmax_max_sub_q88_pkg.sv
// Shared Q8.8 constants and arithmetic helpers for the softmax datapath.
// Signed compare and saturating subtract are used by the max tree and the top.
package softmax_q88_pkg;

  localparam int          Q88_W   = 16;
  localparam logic [15:0] Q88_MIN = 16'h8000;

  function automatic logic [15:0] q88_max(input logic [15:0] a, input logic [15:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  // The true difference a - b is in [-65535, 65535]; only the negative side can leave Q8.8 here.
  function automatic logic [15:0] q88_sat_sub(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] diff;
    diff = {a[15], a} - {b[15], b};
    if (diff[16] && !diff[15]) begin
      return Q88_MIN;
    end else begin
      return diff[15:0];
    end
  endfunction

endpackage

// File: rtl/softmax_max_sub_q88_if.sv
// Vector bus between the stimulus source, the max-subtract stage and the exp stage.
// The source side drives en/valid_in/in_x_flat; the stage returns its results.
interface softmax_max_sub_q88_if #(parameter int N = 8);
  logic              en;
  logic              valid_in;
  logic [N*16-1:0]   in_x_flat;
  logic              valid_out;
  logic [15:0]       max_out;
  logic [N*16-1:0]   sub_x_flat;

  modport master (output en, valid_in, in_x_flat, input valid_out, max_out, sub_x_flat);
  modport slave  (input en, valid_in, in_x_flat, output valid_out, max_out, sub_x_flat);
endinterface

// File: rtl/softmax_max_sub_q88_max_tree.sv
// Registered signed max reduction over N Q8.8 elements, one tree level per stage.
// Result and its valid bit appear LOG2N enabled edges after the input is taken.
module q88_max_tree
  import softmax_q88_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [N*16-1:0]   x_flat_i,
  output logic [15:0]       max_o,
  output logic              valid_o
);
  localparam int LOG2N = $clog2(N);

  for (genvar l = 0; l < LOG2N; l++) begin : g_lvl
    localparam int M = N >> (l + 1);
    logic [2*M*16-1:0] prev_s;
    logic              prev_vld_s;
    logic [M*16-1:0]   node_d;
    logic [M*16-1:0]   node_q;
    logic              vld_q;

    if (l == 0) begin : g_src
      assign prev_s     = x_flat_i;
      assign prev_vld_s = valid_i;
    end else begin : g_src
      assign prev_s     = g_lvl[l-1].node_q;
      assign prev_vld_s = g_lvl[l-1].vld_q;
    end

    // Pairwise max of adjacent operands from the previous level.
    always_comb begin
      node_d = '0;
      for (int k = 0; k < M; k++) begin
        node_d[16*k +: 16] = q88_max(prev_s[32*k +: 16], prev_s[32*k+16 +: 16]);
      end
    end

    // Level register: cleared by reset, held while en is low.
    always_ff @(posedge clk) begin
      if (rst) begin
        node_q <= '0;
        vld_q  <= 1'b0;
      end else if (en_i) begin
        node_q <= node_d;
        vld_q  <= prev_vld_s;
      end
    end
  end

  assign max_o   = g_lvl[LOG2N-1].node_q;
  assign valid_o = g_lvl[LOG2N-1].vld_q;

endmodule

// File: rtl/softmax_max_sub_q88.sv
// Q8.8 softmax first stage: pipelined vector max, then x_i - max with negative saturation.
// The input vector rides a delay line alongside the max tree so both meet at the subtract stage.
module softmax_max_sub_q88
  import softmax_q88_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  softmax_max_sub_q88_if.slave    io
);
  localparam int LOG2N = $clog2(N);

  logic [15:0]          tree_max_s;
  logic                 tree_vld_s;
  logic [N*Q88_W-1:0]   dly_q [LOG2N];
  logic [N*Q88_W-1:0]   sub_d;
  logic [N*Q88_W-1:0]   sub_q;
  logic [15:0]          max_q;
  logic                 valid_q;

  q88_max_tree #(.N(N)) u_tree (
    .clk      (clk),
    .rst      (rst),
    .en_i     (io.en),
    .valid_i  (io.valid_in),
    .x_flat_i (io.in_x_flat),
    .max_o    (tree_max_s),
    .valid_o  (tree_vld_s)
  );

  // Vector delay line matching the tree depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LOG2N; i++) dly_q[i] <= '0;
    end else if (io.en) begin
      dly_q[0] <= io.in_x_flat;
      for (int i = 1; i < LOG2N; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  // Per-element saturating subtract against the tree result.
  always_comb begin
    sub_d = '0;
    for (int k = 0; k < N; k++) begin
      sub_d[16*k +: 16] = q88_sat_sub(dly_q[LOG2N-1][16*k +: 16], tree_max_s);
    end
  end

  // Output stage register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      max_q   <= '0;
      sub_q   <= '0;
    end else if (io.en) begin
      valid_q <= tree_vld_s;
      max_q   <= tree_max_s;
      sub_q   <= sub_d;
    end
  end

  assign io.valid_out  = valid_q;
  assign io.max_out    = max_q;
  assign io.sub_x_flat = sub_q;

endmodule
